interrupt_dispatch: RTL and testbench

Sequences interrupt servicing for the CPU core. It owns the interrupt master enable (IME), including the EI delay, DI and RETI. It selects the highest-priority pending IF&IE source and runs the 5-M-cycle dispatch: two wait cycles, a push of PC high, a push of PC low, and a jump to the vector. It sits between the IF/IE register logic and the CPU core's PC/SP/bus control, and also produces the HALT wake signal.

---
 rtl/interrupt_dispatch.sv | 231 +++++++++++++++++++++++
 tb/tb_interrupt_dispatch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_dispatch.sv
// interrupt_dispatch: owns the interrupt master enable (IME, with EI delay,
// DI and RETI), picks the highest-priority pending IF&IE source and runs the
// 5-M-cycle dispatch (WAIT0, WAIT1, PUSH_HI, PUSH_LO, JUMP). Also produces the
// HALT wake signal.
//
// Optional feature macro: IRQ_LATE_VECTOR_EN
//   undefined : the serviced source is latched when the dispatch starts.
//   defined   : the source is re-evaluated on the PUSH_HI -> PUSH_LO strobe;
//               if nothing is pending then, the dispatch jumps to 16'h0000
//               and clears no IF bit.
module interrupt_dispatch #(
  parameter logic [15:0] VECTOR_BASE = 16'h0040
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mcycle_en,
  input  logic [4:0]  int_flag,
  input  logic [4:0]  int_enable,
  input  logic        ei,
  input  logic        di,
  input  logic        reti,
  input  logic        instr_boundary,
  input  logic        halt,
  input  logic [15:0] pc,
  input  logic [15:0] sp,
  output logic        ime,
  output logic        dispatch,
  output logic        stack_we_l,
  output logic [15:0] stack_addr,
  output logic [7:0]  stack_data,
  output logic        pc_load,
  output logic        sp_load,
  output logic [15:0] pc_value,
  output logic [15:0] sp_value,
  output logic [4:0]  if_clear,
  output logic        wake
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT0,
    ST_WAIT1,
    ST_PUSH_HI,
    ST_PUSH_LO,
    ST_JUMP
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  pending;
  logic [2:0]  pend_idx;
  logic        pend_any;
  logic        start;
  logic        ei_armed;
  logic [15:0] pc_q, sp_q;
  logic [2:0]  src_q;
  logic [15:0] vector;
  logic [4:0]  clear_mask;

  // next-cycle values of the registered outputs
  logic        dispatch_d, stack_we_l_d, pc_load_d, sp_load_d;
  logic [15:0] stack_addr_d, pc_value_d, sp_value_d;
  logic [7:0]  stack_data_d;
  logic [4:0]  if_clear_d;

  assign pending  = int_flag & int_enable;
  assign pend_any = |pending;
  assign start    = (state_q == ST_IDLE) && instr_boundary && ime && pend_any;

  // Priority encoder: the lowest set pending bit wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    pend_idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pending[i]) pend_idx = 3'(i);
    end
  end

  // IME and the one-boundary EI delay; decode pulses are ignored mid-dispatch.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      ime      <= 1'b0;
      ei_armed <= 1'b0;
    end else if (mcycle_en) begin
      if (start) begin
        ime      <= 1'b0;
        ei_armed <= 1'b0;
      end else if (!dispatch) begin
        if (di) begin
          ime      <= 1'b0;
          ei_armed <= 1'b0;
        end else if (reti) begin
          ime      <= 1'b1;
          ei_armed <= 1'b0;
        end else if (ei && !ime) begin
          ei_armed <= 1'b1;
        end else if (ei_armed && instr_boundary) begin
          // The boundary that fetches the instruction after EI enables IME,
          // so the following boundary is the first one that can be preempted.
          ime      <= 1'b1;
          ei_armed <= 1'b0;
        end
      end
    end
  end

  // Capture PC/SP at entry and latch the serviced source.
`ifdef IRQ_LATE_VECTOR_EN
  logic src_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= 16'h0000;
      sp_q        <= 16'h0000;
      src_q       <= 3'd0;
      src_valid_q <= 1'b0;
    end else if (mcycle_en) begin
      if (start) begin
        pc_q <= pc;
        sp_q <= sp;
      end
      if (state_q == ST_PUSH_HI) begin
        src_q       <= pend_idx;
        src_valid_q <= pend_any;
      end
    end
  end

  assign vector     = src_valid_q ? (VECTOR_BASE + {10'd0, src_q, 3'd0}) : 16'h0000;
  assign clear_mask = src_valid_q ? (5'b00001 << src_q) : 5'b00000;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= 16'h0000;
      sp_q  <= 16'h0000;
      src_q <= 3'd0;
    end else if (mcycle_en && start) begin
      pc_q  <= pc;
      sp_q  <= sp;
      src_q <= pend_idx;
    end
  end

  assign vector     = VECTOR_BASE + {10'd0, src_q, 3'd0};
  assign clear_mask = 5'b00001 << src_q;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else if (mcycle_en) state_q <= state_d;
  end

  // Next state plus the output values that state will present.
  always_comb begin
    state_d      = state_q;
    dispatch_d   = 1'b0;
    stack_we_l_d = 1'b1;
    stack_addr_d = 16'h0000;
    stack_data_d = 8'h00;
    pc_load_d    = 1'b0;
    sp_load_d    = 1'b0;
    pc_value_d   = 16'h0000;
    sp_value_d   = 16'h0000;
    if_clear_d   = 5'b00000;

    case (state_q)
      ST_IDLE:    if (start) state_d = ST_WAIT0;
      ST_WAIT0:   state_d = ST_WAIT1;
      ST_WAIT1:   state_d = ST_PUSH_HI;
      ST_PUSH_HI: state_d = ST_PUSH_LO;
      ST_PUSH_LO: state_d = ST_JUMP;
      ST_JUMP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    dispatch_d = (state_d != ST_IDLE);

    case (state_d)
      ST_PUSH_HI: begin
        stack_we_l_d = 1'b0;
        stack_addr_d = sp_q - 16'd1;
        stack_data_d = pc_q[15:8];
      end
      ST_PUSH_LO: begin
        stack_we_l_d = 1'b0;
        stack_addr_d = sp_q - 16'd2;
        stack_data_d = pc_q[7:0];
      end
      ST_JUMP: begin
        pc_load_d  = 1'b1;
        pc_value_d = vector;
        sp_load_d  = 1'b1;
        sp_value_d = sp_q - 16'd2;
        if_clear_d = clear_mask;
      end
      default: ;
    endcase
  end

  // Output registers: each value holds for the whole M-cycle of its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dispatch   <= 1'b0;
      stack_we_l <= 1'b1;
      stack_addr <= 16'h0000;
      stack_data <= 8'h00;
      pc_load    <= 1'b0;
      sp_load    <= 1'b0;
      pc_value   <= 16'h0000;
      sp_value   <= 16'h0000;
      if_clear   <= 5'b00000;
      wake       <= 1'b0;
    end else if (mcycle_en) begin
      dispatch   <= dispatch_d;
      stack_we_l <= stack_we_l_d;
      stack_addr <= stack_addr_d;
      stack_data <= stack_data_d;
      pc_load    <= pc_load_d;
      sp_load    <= sp_load_d;
      pc_value   <= pc_value_d;
      sp_value   <= sp_value_d;
      if_clear   <= if_clear_d;
      // Wake is independent of IME: with IME=0 the CPU just resumes.
      wake       <= halt & pend_any;
    end
  end

endmodule

// File: tb/tb_interrupt_dispatch.sv
// Directed testbench for interrupt_dispatch. M-cycle strobe every 4 clocks;
// outputs are sampled on the falling edge after the strobe's non-strobe clocks.
module tb_interrupt_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mcycle_en;
  logic [4:0]  int_flag, int_enable;
  logic        ei, di, reti, instr_boundary, halt;
  logic [15:0] pc, sp;
  logic        ime, dispatch, stack_we_l, pc_load, sp_load, wake;
  logic [15:0] stack_addr, pc_value, sp_value;
  logic [7:0]  stack_data;
  logic [4:0]  if_clear;

  int checks = 0;
  int errors = 0;

  logic watch = 1'b0;
  logic pc_load_seen = 1'b0;
  logic stack_seen = 1'b0;

  interrupt_dispatch dut (
    .clk(clk), .rst_n(rst_n), .mcycle_en(mcycle_en),
    .int_flag(int_flag), .int_enable(int_enable),
    .ei(ei), .di(di), .reti(reti),
    .instr_boundary(instr_boundary), .halt(halt),
    .pc(pc), .sp(sp),
    .ime(ime), .dispatch(dispatch),
    .stack_we_l(stack_we_l), .stack_addr(stack_addr), .stack_data(stack_data),
    .pc_load(pc_load), .sp_load(sp_load),
    .pc_value(pc_value), .sp_value(sp_value),
    .if_clear(if_clear), .wake(wake)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Any PC load or stack write while watch is set is an error.
  always @(negedge clk) begin
    if (watch && pc_load === 1'b1) pc_load_seen = 1'b1;
    if (watch && stack_we_l === 1'b0) stack_seen = 1'b1;
  end

  function automatic logic [66:0] pack(
    input logic ime_v, input logic dsp, input logic we_l,
    input logic [15:0] addr, input logic [7:0] data,
    input logic pcl, input logic spl,
    input logic [15:0] pcv, input logic [15:0] spv,
    input logic [4:0] clr, input logic wk);
    return {ime_v, dsp, we_l, addr, data, pcl, spl, pcv, spv, clr, wk};
  endfunction

  function automatic logic [66:0] act();
    return pack(ime, dispatch, stack_we_l, stack_addr, stack_data,
                pc_load, sp_load, pc_value, sp_value, if_clear, wake);
  endfunction

  // One M-cycle: strobe on one clock, then three clocks without strobe.
  task automatic step();
    @(negedge clk); mcycle_en = 1'b1;
    @(negedge clk); mcycle_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [66:0] rst_v;
    rst_v = pack(0, 0, 1, 16'h0, 8'h0, 0, 0, 16'h0, 16'h0, 5'h0, 0);
    checks++;
    if (act() !== rst_v) begin
      errors++;
      $display("FAIL reset_asserted: got %h expected %h", act(), rst_v);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    checks++;
    if (act() !== rst_v) begin
      errors++;
      $display("FAIL reset_released: got %h expected %h", act(), rst_v);
    end
  endtask

  task automatic test_wake();
    logic [66:0] exp_v;
    int_flag = 5'h01; int_enable = 5'h01; halt = 1'b1; instr_boundary = 1'b1;
    // No strobe yet: wake must not move on ordinary clocks.
    @(negedge clk); @(negedge clk);
    checks++;
    if (wake !== 1'b0) begin
      errors++;
      $display("FAIL wake_no_strobe: got %b expected 0", wake);
    end
    exp_v = pack(0, 0, 1, 16'h0, 8'h0, 0, 0, 16'h0, 16'h0, 5'h0, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (act() !== exp_v) begin
        errors++;
        $display("FAIL wake_ime0 step %0d: got %h expected %h", k, act(), exp_v);
      end
    end
    halt = 1'b0;
    step();
    checks++;
    if (wake !== 1'b0) begin
      errors++;
      $display("FAIL wake_halt_low: got %b expected 0", wake);
    end
    int_flag = 5'h00; int_enable = 5'h00; instr_boundary = 1'b0;
  endtask

  // Full dispatch: f/e at entry, f_mid/e_mid applied during WAIT1.
  // A RETI is also pulsed during WAIT1 and must be ignored (IME stays 0).
  task automatic run_dispatch(input string name,
                              input logic [4:0] f, input logic [4:0] e,
                              input logic [4:0] f_mid, input logic [4:0] e_mid,
                              input logic [15:0] pc_in, input logic [15:0] sp_in,
                              input logic [15:0] exp_vec, input logic [4:0] exp_clr);
    logic [66:0] exp_v [6];
    reti = 1'b1; step(); reti = 1'b0;
    checks++;
    if (ime !== 1'b1) begin
      errors++;
      $display("FAIL %s reti_sets_ime: got %b expected 1", name, ime);
    end
    exp_v[0] = pack(0, 1, 1, 16'h0, 8'h0, 0, 0, 16'h0, 16'h0, 5'h0, 0);
    exp_v[1] = exp_v[0];
    exp_v[2] = pack(0, 1, 0, sp_in - 16'd1, pc_in[15:8], 0, 0, 16'h0, 16'h0, 5'h0, 0);
    exp_v[3] = pack(0, 1, 0, sp_in - 16'd2, pc_in[7:0], 0, 0, 16'h0, 16'h0, 5'h0, 0);
    exp_v[4] = pack(0, 1, 1, 16'h0, 8'h0, 1, 1, exp_vec, sp_in - 16'd2, exp_clr, 0);
    exp_v[5] = pack(0, 0, 1, 16'h0, 8'h0, 0, 0, 16'h0, 16'h0, 5'h0, 0);
    int_flag = f; int_enable = e; pc = pc_in; sp = sp_in; instr_boundary = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (act() !== exp_v[k]) begin
        errors++;
        $display("FAIL %s state %0d: got %h expected %h", name, k, act(), exp_v[k]);
      end
      if (k == 0) begin
        instr_boundary = 1'b0; pc = ~pc_in; sp = ~sp_in;
      end
      if (k == 1) begin
        int_flag = f_mid; int_enable = e_mid; reti = 1'b1;
      end
      if (k == 2) reti = 1'b0;
    end
    int_flag = 5'h00; int_enable = 5'h00;
  endtask

  task automatic test_dispatch();
    run_dispatch("basic", 5'h14, 5'h1F, 5'h14, 5'h1F, 16'h1234, 16'hFFFE, 16'h0050, 5'h04);
    run_dispatch("bit3", 5'h18, 5'h1F, 5'h18, 5'h1F, 16'h4000, 16'hC100, 16'h0058, 5'h08);
  endtask

  task automatic test_sp_wrap();
    run_dispatch("sp_wrap", 5'h10, 5'h10, 5'h10, 5'h10, 16'hABCD, 16'h0001, 16'h0060, 5'h10);
  endtask

  task automatic test_mid_change();
`ifdef IRQ_LATE_VECTOR_EN
    run_dispatch("higher_mid", 5'h04, 5'h1F, 5'h05, 5'h1F, 16'h0100, 16'hD000, 16'h0040, 5'h01);
    run_dispatch("ie_cleared", 5'h04, 5'h04, 5'h04, 5'h00, 16'h0200, 16'hD000, 16'h0000, 5'h00);
`else
    run_dispatch("higher_mid", 5'h04, 5'h1F, 5'h05, 5'h1F, 16'h0100, 16'hD000, 16'h0050, 5'h04);
    run_dispatch("ie_cleared", 5'h04, 5'h04, 5'h04, 5'h00, 16'h0200, 16'hD000, 16'h0050, 5'h04);
`endif
  endtask

  task automatic test_ei_delay();
    int_flag = 5'h01; int_enable = 5'h01; instr_boundary = 1'b0; pc = 16'h0150; sp = 16'hDFF0;
    // EI: dispatch only at the second boundary.
    ei = 1'b1; step(); ei = 1'b0;
    checks++;
    if ({ime, dispatch} !== 2'b00) begin
      errors++;
      $display("FAIL ei_strobe: got ime/dsp %b expected 00", {ime, dispatch});
    end
    instr_boundary = 1'b1; step();
    checks++;
    if ({ime, dispatch} !== 2'b10) begin
      errors++;
      $display("FAIL ei_first_boundary: got ime/dsp %b expected 10", {ime, dispatch});
    end
    step();
    checks++;
    if ({ime, dispatch} !== 2'b01) begin
      errors++;
      $display("FAIL ei_second_boundary: got ime/dsp %b expected 01", {ime, dispatch});
    end
    instr_boundary = 1'b0;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if ({ime, dispatch} !== 2'b00) begin
      errors++;
      $display("FAIL ei_dispatch_end: got ime/dsp %b expected 00", {ime, dispatch});
    end
    // EI, first boundary, then DI: never dispatches.
    ei = 1'b1; step(); ei = 1'b0;
    instr_boundary = 1'b1; step(); instr_boundary = 1'b0;
    di = 1'b1; step(); di = 1'b0;
    checks++;
    if (ime !== 1'b0) begin
      errors++;
      $display("FAIL di_clears_ime: got %b expected 0", ime);
    end
    instr_boundary = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({ime, dispatch} !== 2'b00) begin
        errors++;
        $display("FAIL di_no_dispatch %0d: got ime/dsp %b expected 00", k, {ime, dispatch});
      end
    end
    // DI before the first boundary cancels the armed EI.
    instr_boundary = 1'b0;
    ei = 1'b1; step(); ei = 1'b0;
    di = 1'b1; step(); di = 1'b0;
    instr_boundary = 1'b1; step(); step();
    checks++;
    if ({ime, dispatch} !== 2'b00) begin
      errors++;
      $display("FAIL di_cancels_ei: got ime/dsp %b expected 00", {ime, dispatch});
    end
    // EI and DI in the same strobe: DI wins.
    instr_boundary = 1'b0;
    ei = 1'b1; di = 1'b1; step(); ei = 1'b0; di = 1'b0;
    instr_boundary = 1'b1; step(); step();
    checks++;
    if ({ime, dispatch} !== 2'b00) begin
      errors++;
      $display("FAIL ei_di_same: got ime/dsp %b expected 00", {ime, dispatch});
    end
    instr_boundary = 1'b0; int_flag = 5'h00; int_enable = 5'h00;
  endtask

  task automatic test_reset_mid();
    logic [66:0] rst_v;
    rst_v = pack(0, 0, 1, 16'h0, 8'h0, 0, 0, 16'h0, 16'h0, 5'h0, 0);
    reti = 1'b1; step(); reti = 1'b0;
    int_flag = 5'h04; int_enable = 5'h04; pc = 16'h5678; sp = 16'hC000; instr_boundary = 1'b1;
    step(); instr_boundary = 1'b0;
    step(); step();
    checks++;
    if ({stack_we_l, stack_addr, stack_data} !== {1'b0, 16'hBFFF, 8'h56}) begin
      errors++;
      $display("FAIL rst_mid_push_hi: got %h expected %h",
               {stack_we_l, stack_addr, stack_data}, {1'b0, 16'hBFFF, 8'h56});
    end
    #2 rst_n = 1'b0;
    #1;
    watch = 1'b1;
    checks++;
    if (act() !== rst_v) begin
      errors++;
      $display("FAIL rst_mid_async: got %h expected %h", act(), rst_v);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (act() !== rst_v) begin
        errors++;
        $display("FAIL rst_mid_after %0d: got %h expected %h", k, act(), rst_v);
      end
    end
    watch = 1'b0;
    checks++;
    if ({pc_load_seen, stack_seen} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_no_activity: got pcload/stack %b expected 00",
               {pc_load_seen, stack_seen});
    end
    int_flag = 5'h00; int_enable = 5'h00;
  endtask

  initial begin
    rst_n = 1'b0; mcycle_en = 1'b0;
    int_flag = 5'h00; int_enable = 5'h00;
    ei = 1'b0; di = 1'b0; reti = 1'b0; instr_boundary = 1'b0; halt = 1'b0;
    pc = 16'h0000; sp = 16'h0000;
    repeat (3) @(negedge clk);
    test_reset();
    test_wake();
    test_dispatch();
    test_sp_wrap();
    test_mid_change();
    test_ei_delay();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
